io_stim_sequencer: RTL and testbench

- Synthesizable, parametrised switch/LED stimulus-and-check engine for exercising the minisys CPU on the board, or in a wrapper bench, without a hand-written timed sequence.
- Holds the DUT in reset for a set time, then walks a loadable table of switch vectors. Each vector is held for its programmed cycle count.
- At the end of each step it samples the LED bus, compares it against a masked expected value, and counts and records mismatches.
- Supports one-shot and continuous-loop modes.

---
 rtl/io_stim_sequencer_if.sv | 43 ++++
 rtl/io_stim_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_io_stim_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/io_stim_sequencer_if.sv
// Control, table-load, status and DUT-facing switch/LED signals of the stimulus sequencer.
// The master side is the controller or bench. The slave side is the sequencer itself.
interface io_stim_sequencer_if #(
  parameter int unsigned SW_W   = 24,
  parameter int unsigned LED_W  = 24,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned HOLD_W = 16
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [SW_W-1:0]   cfg_sw;
  logic [LED_W-1:0]  cfg_exp;
  logic [LED_W-1:0]  cfg_mask;
  logic [HOLD_W-1:0] cfg_hold;
  logic [AW:0]       num_steps;
  logic              loop_mode;
  logic              start;
  logic              abort;
  logic              dut_rst;
  logic [SW_W-1:0]   switch;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step_idx;
  logic [15:0]       mismatch_cnt;
  logic              fail;
  logic [AW-1:0]     fail_step;
  logic [LED_W-1:0]  fail_led;

  modport master (
    output cfg_we, cfg_addr, cfg_sw, cfg_exp, cfg_mask, cfg_hold,
    output num_steps, loop_mode, start, abort, led,
    input  dut_rst, switch, busy, done, step_idx, mismatch_cnt, fail, fail_step, fail_led
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sw, cfg_exp, cfg_mask, cfg_hold,
    input  num_steps, loop_mode, start, abort, led,
    output dut_rst, switch, busy, done, step_idx, mismatch_cnt, fail, fail_step, fail_led
  );
endinterface

// File: rtl/io_stim_sequencer.sv
// Switch/LED stimulus-and-check engine: resets the DUT, then walks a table of switch vectors,
// comparing the LEDs against a masked expected value at the end of each step.
module io_stim_sequencer #(
  parameter int unsigned SW_W       = 24,
  parameter int unsigned LED_W      = 24,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HOLD_W     = 16,
  parameter int unsigned RESET_HOLD = 700
) (
  input logic             clk,
  input logic             rst,
  io_stim_sequencer_if.slave bus
);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW    = AW + 1;
  localparam int unsigned RST_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  typedef struct packed {
    logic [SW_W-1:0]   sw;
    logic [LED_W-1:0]  exp;
    logic [LED_W-1:0]  mask;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              dut_rst_q, dut_rst_d;
  logic [SW_W-1:0]   switch_q, switch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     step_idx_q, step_idx_d;
  logic [15:0]       mismatch_q, mismatch_d;
  logic              fail_q, fail_d;
  logic [AW-1:0]     fail_step_q, fail_step_d;
  logic [LED_W-1:0]  fail_led_q, fail_led_d;
  logic [AW-1:0]     n_last_q, n_last_d;
  logic              loop_q, loop_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  entry_t            table_q [DEPTH];
  entry_t            cur, nxt, first;
  logic [AW-1:0]     nxt_idx;
  logic [NW-1:0]     n_clamp;
  logic              mism;
  logic              start_ok;
  logic              addr_ok;
  logic              wr_en;

  // A hold of 0 behaves as 1: the down-counter is loaded with hold-1, floored at 0.
  function automatic logic [HOLD_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
    return (h == '0) ? '0 : h - HOLD_W'(1);
  endfunction

  // With a power-of-two depth every address is in range.
  if (DEPTH == (1 << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = ({1'b0, bus.cfg_addr} < NW'(DEPTH));
  end

  assign wr_en = bus.cfg_we && addr_ok && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Stimulus table; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_q[bus.cfg_addr] <= '{sw: bus.cfg_sw, exp: bus.cfg_exp, mask: bus.cfg_mask,
                                 hold: bus.cfg_hold};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dut_rst_q   <= 1'b1;
      switch_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_idx_q  <= '0;
      mismatch_q  <= '0;
      fail_q      <= 1'b0;
      fail_step_q <= '0;
      fail_led_q  <= '0;
      n_last_q    <= '0;
      loop_q      <= 1'b0;
      rst_cnt_q   <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dut_rst_q   <= dut_rst_d;
      switch_q    <= switch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_idx_q  <= step_idx_d;
      mismatch_q  <= mismatch_d;
      fail_q      <= fail_d;
      fail_step_q <= fail_step_d;
      fail_led_q  <= fail_led_d;
      n_last_q    <= n_last_d;
      loop_q      <= loop_d;
      rst_cnt_q   <= rst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    dut_rst_d   = dut_rst_q;
    switch_d    = switch_q;
    busy_d      = busy_q;
    done_d      = done_q;
    step_idx_d  = step_idx_q;
    mismatch_d  = mismatch_q;
    fail_d      = fail_q;
    fail_step_d = fail_step_q;
    fail_led_d  = fail_led_q;
    n_last_d    = n_last_q;
    loop_d      = loop_q;
    rst_cnt_d   = rst_cnt_q;
    hold_cnt_d  = hold_cnt_q;

    cur      = table_q[step_idx_q];
    first    = table_q[0];
    nxt_idx  = (step_idx_q < n_last_q) ? step_idx_q + AW'(1) : '0;
    nxt      = table_q[nxt_idx];
    mism     = |((bus.led ^ cur.exp) & cur.mask);
    start_ok = bus.start && (bus.num_steps != '0);
    n_clamp  = (bus.num_steps > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_steps;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d     = S_RST;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          dut_rst_d   = 1'b1;
          switch_d    = first.sw;
          rst_cnt_d   = RST_W'(RESET_HOLD - 1);
          n_last_d    = AW'(n_clamp - NW'(1));
          loop_d      = bus.loop_mode;
          mismatch_d  = '0;
          fail_d      = 1'b0;
          fail_step_d = '0;
          fail_led_d  = '0;
        end
      end

      S_RST: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          dut_rst_d = 1'b1;
        end else if (rst_cnt_q == '0) begin
          state_d    = S_STEP;
          dut_rst_d  = 1'b0;
          step_idx_d = '0;
          switch_d   = first.sw;
          hold_cnt_d = hold_load(first.hold);
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end

      S_STEP: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b0;
          dut_rst_d = 1'b1;
        end else if (hold_cnt_q == '0) begin
          // Last cycle of the step: sample LEDs, then advance, wrap or finish.
          if (mism) begin
            if (mismatch_q != 16'hFFFF) mismatch_d = mismatch_q + 16'd1;
            if (!fail_q) begin
              fail_d      = 1'b1;
              fail_step_d = step_idx_q;
              fail_led_d  = bus.led;
            end
          end
          if ((step_idx_q < n_last_q) || loop_q) begin
            step_idx_d = nxt_idx;
            switch_d   = nxt.sw;
            hold_cnt_d = hold_load(nxt.hold);
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dut_rst      = dut_rst_q;
  assign bus.switch       = switch_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.step_idx     = step_idx_q;
  assign bus.mismatch_cnt = mismatch_q;
  assign bus.fail         = fail_q;
  assign bus.fail_step    = fail_step_q;
  assign bus.fail_led     = fail_led_q;
endmodule

// File: tb/tb_io_stim_sequencer.sv
// Directed bench for io_stim_sequencer with the LED bus looped back from the switch bus.
module tb_io_stim_sequencer;
  localparam int unsigned SW_W   = 24;
  localparam int unsigned LED_W  = 24;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned HOLD_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_stim_sequencer_if #(.SW_W(SW_W), .LED_W(LED_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus ();

  io_stim_sequencer #(.SW_W(SW_W), .LED_W(LED_W), .DEPTH(DEPTH), .HOLD_W(HOLD_W),
                      .RESET_HOLD(700)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.led = bus.switch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [23:0] sw, input logic [23:0] ex,
                    input logic [23:0] mk, input logic [15:0] h);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_sw   = sw;
    bus.cfg_exp  = ex;
    bus.cfg_mask = mk;
    bus.cfg_hold = h;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic go(input logic [3:0] n, input logic lp);
    bus.num_steps = n;
    bus.loop_mode = lp;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_sw = '0; bus.cfg_exp = '0;
    bus.cfg_mask = '0; bus.cfg_hold = '0; bus.num_steps = '0; bus.loop_mode = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_dut_rst", 32'(bus.dut_rst), 32'd1);
    check("rst_switch",  32'(bus.switch), 32'd0);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_done",    32'(bus.done), 32'd0);
    check("rst_mism",    32'(bus.mismatch_cnt), 32'd0);
    check("rst_fail",    32'(bus.fail), 32'd0);
    #10 rst = 1'b0;
    tick();

    // Single step, loopback matches.
    wr(3'd0, 24'h2000AC, 24'h0000AC, 24'h0000FF, 16'd200);
    go(4'd1, 1'b0);
    check("t1_busy",   32'(bus.busy), 32'd1);
    check("t1_switch", 32'(bus.switch), 32'h2000AC);
    tickn(699);
    check("t1_rst_hi", 32'(bus.dut_rst), 32'd1);
    tick();
    check("t1_rst_lo", 32'(bus.dut_rst), 32'd0);
    tickn(199);
    check("t1_notdone", 32'(bus.done), 32'd0);
    tick();
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_idle", 32'(bus.busy), 32'd0);
    check("t1_mism", 32'(bus.mismatch_cnt), 32'd0);
    check("t1_fail", 32'(bus.fail), 32'd0);
    check("t1_hold_sw", 32'(bus.switch), 32'h2000AC);

    // Four steps, entry 2 expects a wrong value.
    wr(3'd0, 24'h20005C, 24'h20005C, 24'hFFFFFF, 16'd10);
    wr(3'd1, 24'h40005C, 24'h40005C, 24'hFFFFFF, 16'd10);
    wr(3'd2, 24'h60005C, 24'h60005D, 24'hFFFFFF, 16'd10);
    wr(3'd3, 24'hA00D00, 24'hA00D00, 24'hFFFFFF, 16'd10);
    go(4'd4, 1'b0);
    tickn(700);
    check("t2_s0", 32'(bus.switch), 32'h20005C);
    tickn(10);
    check("t2_s1", 32'(bus.switch), 32'h40005C);
    check("t2_i1", 32'(bus.step_idx), 32'd1);
    tickn(10);
    check("t2_s2", 32'(bus.switch), 32'h60005C);
    check("t2_nofail", 32'(bus.fail), 32'd0);
    tickn(10);
    check("t2_s3", 32'(bus.switch), 32'hA00D00);
    check("t2_fail", 32'(bus.fail), 32'd1);
    check("t2_fstep", 32'(bus.fail_step), 32'd2);
    check("t2_fled", 32'(bus.fail_led), 32'h60005C);
    tickn(10);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_mism", 32'(bus.mismatch_cnt), 32'd1);

    // Loop of two one-cycle steps, entry 1 always mismatches, then abort.
    wr(3'd0, 24'h111111, 24'h000000, 24'h000000, 16'd0);
    wr(3'd1, 24'h222222, 24'h000000, 24'hFFFFFF, 16'd0);
    go(4'd2, 1'b1);
    tickn(700);
    check("t3_i0", 32'(bus.step_idx), 32'd0);
    tick();
    check("t3_i1", 32'(bus.step_idx), 32'd1);
    check("t3_sw1", 32'(bus.switch), 32'h222222);
    tick();
    check("t3_i0b", 32'(bus.step_idx), 32'd0);
    check("t3_m1", 32'(bus.mismatch_cnt), 32'd1);
    tick();
    check("t3_i1b", 32'(bus.step_idx), 32'd1);
    check("t3_norst", 32'(bus.dut_rst), 32'd0);
    tick();
    check("t3_m2", 32'(bus.mismatch_cnt), 32'd2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t3_ab_busy", 32'(bus.busy), 32'd0);
    check("t3_ab_done", 32'(bus.done), 32'd0);
    check("t3_ab_rst",  32'(bus.dut_rst), 32'd1);
    check("t3_ab_mism", 32'(bus.mismatch_cnt), 32'd2);
    check("t3_ab_fstep", 32'(bus.fail_step), 32'd1);
    check("t3_ab_fled", 32'(bus.fail_led), 32'h222222);

    // num_steps clamp, with writes and start ignored while busy.
    for (int i = 0; i < 8; i++) wr(3'(i), 24'(i), 24'h0, 24'h0, 16'd1);
    go(4'd15, 1'b0);
    check("t4_clr_fail", 32'(bus.fail), 32'd0);
    check("t4_clr_mism", 32'(bus.mismatch_cnt), 32'd0);
    tickn(700);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd5; bus.cfg_sw = 24'hFFFFFF; bus.cfg_hold = 16'd1;
    bus.start = 1'b1; bus.num_steps = 4'd2;
    tick();
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    check("t4_i1", 32'(bus.step_idx), 32'd1);
    tickn(4);
    check("t4_sw5", 32'(bus.switch), 32'd5);
    tickn(2);
    check("t4_i7", 32'(bus.step_idx), 32'd7);
    check("t4_busy7", 32'(bus.busy), 32'd1);
    tick();
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_swlast", 32'(bus.switch), 32'd7);
    bus.num_steps = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t4_zero_busy", 32'(bus.busy), 32'd0);
    check("t4_zero_done", 32'(bus.done), 32'd1);

    // Asynchronous reset in the middle of a failing loop.
    wr(3'd0, 24'hABCDEF, 24'h000000, 24'hFFFFFF, 16'd0);
    go(4'd1, 1'b1);
    tickn(710);
    check("t5_busy", 32'(bus.busy), 32'd1);
    check("t5_mism", 32'(bus.mismatch_cnt), 32'd10);
    rst = 1'b1;
    #1;
    check("t5_r_switch", 32'(bus.switch), 32'd0);
    check("t5_r_busy",   32'(bus.busy), 32'd0);
    check("t5_r_rst",    32'(bus.dut_rst), 32'd1);
    check("t5_r_mism",   32'(bus.mismatch_cnt), 32'd0);
    check("t5_r_fail",   32'(bus.fail), 32'd0);
    check("t5_r_idx",    32'(bus.step_idx), 32'd0);
    #2 rst = 1'b0;
    tick();

    // Saturating mismatch counter; first failure is entry 1.
    wr(3'd0, 24'h000010, 24'h000000, 24'h000000, 16'd0);
    for (int i = 1; i < 8; i++) wr(3'(i), 24'h000010 + 24'(i), 24'h0, 24'hFFFFFF, 16'd0);
    go(4'd8, 1'b1);
    tickn(708);
    check("t6_m7", 32'(bus.mismatch_cnt), 32'd7);
    check("t6_fstep", 32'(bus.fail_step), 32'd1);
    check("t6_fled", 32'(bus.fail_led), 32'h000011);
    tickn(75000);
    check("t6_sat", 32'(bus.mismatch_cnt), 32'h0000FFFF);
    check("t6_fstep_kept", 32'(bus.fail_step), 32'd1);
    check("t6_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t6_ab_busy", 32'(bus.busy), 32'd0);
    check("t6_ab_sat", 32'(bus.mismatch_cnt), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
